// File: rtl/skip_adder_pipe_pkg.sv
// Shared defaults for the pipelined carry-skip adder and its bench.
// Both the RTL and the testbench import these so the geometry is defined in one place.
package skip_adder_pipe_pkg;

   localparam int unsigned DEF_WIDTH  = 128;
   localparam int unsigned DEF_B      = 4;
   localparam int unsigned DEF_STAGES = 4;

endpackage

// File: rtl/skip_block.sv
// B-bit ripple-carry block with group propagate and a 2:1 carry-skip select.
// When every bit propagates, the incoming carry bypasses the ripple chain.
module skip_block #(
   parameter int unsigned B = 4
) (
   input  logic [B-1:0] i_a,
   input  logic [B-1:0] i_b,
   input  logic         i_c,
   output logic [B-1:0] o_s,
   output logic         o_c,
   output logic         o_p
);

   logic [B-1:0] w_x;
   logic         w_rc;

   assign w_x = i_a ^ i_b;

   always_comb begin
      logic v_c;
      v_c = i_c;
      o_s = '0;
      for (int i = 0; i < B; i++) begin
         o_s[i] = w_x[i] ^ v_c;
         v_c    = (i_a[i] & i_b[i]) | (w_x[i] & v_c);
      end
      w_rc = v_c;
   end

   assign o_p = &w_x;
   assign o_c = o_p ? i_c : w_rc;

endmodule

// File: rtl/skip_adder_pipe.sv
// Pipelined carry-skip adder/subtractor with valid/ready handshake on both sides.
// Segment k of the sum is produced in stage k+1; the whole pipe freezes on output backpressure.
module skip_adder_pipe
   import skip_adder_pipe_pkg::*;
#(
   parameter int unsigned WIDTH  = DEF_WIDTH,
   parameter int unsigned B      = DEF_B,
   parameter int unsigned STAGES = DEF_STAGES
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             p0
);

   localparam int unsigned SEG  = WIDTH / STAGES;
   localparam int unsigned NBLK = SEG / B;
   localparam int unsigned MSB  = WIDTH - 1;

   if ((WIDTH % (B * STAGES)) != 0) begin : g_bad_cfg
      $error("skip_adder_pipe: WIDTH must be a multiple of B*STAGES");
   end

   logic                         w_advance;
   logic [WIDTH-1:0]             w_op_b;
   logic                         w_c0;
   logic                         w_ovf;
   logic                         w_unused;

   // Entry k feeds the logic that sums segment k.
   logic [STAGES-1:0]            r_valid;
   logic [STAGES-1:0]            r_c;
   logic [STAGES-1:0]            r_p;
   logic [STAGES-1:0][WIDTH-1:0] r_a;
   logic [STAGES-1:0][WIDTH-1:0] r_b;
   logic [STAGES-1:0][WIDTH-1:0] r_sum;

   logic [STAGES-1:0][WIDTH-1:0] w_sum_nxt;
   logic [STAGES-1:0]            w_c_nxt;
   logic [STAGES-1:0]            w_p_nxt;

   logic                         r_out_valid;
   logic [WIDTH-1:0]             r_sum_o;
   logic                         r_cout;
   logic                         r_ovf;
   logic                         r_p0;

   assign w_advance = !(r_out_valid && !out_ready);
   assign w_op_b    = sub ? ~b : b;
   assign w_c0      = sub | cin;

   for (genvar gk = 0; gk < STAGES; gk++) begin : g_stage
      logic [SEG-1:0]  w_seg;
      logic [NBLK-1:0] w_pv;

      for (genvar gj = 0; gj < NBLK; gj++) begin : g_blk
         logic w_ci;
         logic w_co;

         if (gj == 0) begin : g_head
            assign w_ci = r_c[gk];
         end else begin : g_chain
            assign w_ci = g_blk[gj-1].w_co;
         end

         skip_block #(
            .B (B)
         ) u_skip (
            .i_a (r_a[gk][gk*SEG + gj*B +: B]),
            .i_b (r_b[gk][gk*SEG + gj*B +: B]),
            .i_c (w_ci),
            .o_s (w_seg[gj*B +: B]),
            .o_c (w_co),
            .o_p (w_pv[gj])
         );
      end

      // Sum bits at and above this segment are still zero, so OR merges in place.
      assign w_sum_nxt[gk] = r_sum[gk] | (WIDTH'(w_seg) << (gk * SEG));
      assign w_c_nxt[gk]   = g_blk[NBLK-1].w_co;
      assign w_p_nxt[gk]   = r_p[gk] & (&w_pv);
   end

   assign w_ovf = (r_a[STAGES-1][MSB] == r_b[STAGES-1][MSB]) &&
                  (w_sum_nxt[STAGES-1][MSB] != r_a[STAGES-1][MSB]);

   // Only the top segment and sign bits of the last entry are consumed.
   assign w_unused = ^{r_a[STAGES-1], r_b[STAGES-1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid     <= '0;
         r_c         <= '0;
         r_p         <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_sum       <= '0;
         r_out_valid <= 1'b0;
         r_sum_o     <= '0;
         r_cout      <= 1'b0;
         r_ovf       <= 1'b0;
         r_p0        <= 1'b0;
      end else if (w_advance) begin
         r_valid[0] <= in_valid;
         r_a[0]     <= a;
         r_b[0]     <= w_op_b;
         r_sum[0]   <= '0;
         r_c[0]     <= w_c0;
         r_p[0]     <= 1'b1;
         for (int k = 1; k < STAGES; k++) begin
            r_valid[k] <= r_valid[k-1];
            r_a[k]     <= r_a[k-1];
            r_b[k]     <= r_b[k-1];
            r_sum[k]   <= w_sum_nxt[k-1];
            r_c[k]     <= w_c_nxt[k-1];
            r_p[k]     <= w_p_nxt[k-1];
         end
         r_out_valid <= r_valid[STAGES-1];
         // Bubbles leave the result registers untouched.
         if (r_valid[STAGES-1]) begin
            r_sum_o <= w_sum_nxt[STAGES-1];
            r_cout  <= w_c_nxt[STAGES-1];
            r_ovf   <= w_ovf;
            r_p0    <= w_p_nxt[STAGES-1];
         end
      end
   end

   assign in_ready  = w_advance;
   assign out_valid = r_out_valid;
   assign sum       = r_sum_o;
   assign cout      = r_cout;
   assign ovf       = r_ovf;
   assign p0        = r_p0;

endmodule

// File: tb/tb_skip_adder_pipe.sv
// Scoreboard bench for skip_adder_pipe: directed corner cases, backpressure,
// mid-flight reset and a randomised handshake run.
module tb_skip_adder_pipe;
   import skip_adder_pipe_pkg::*;

   localparam int unsigned W   = DEF_WIDTH;
   localparam int unsigned STG = DEF_STAGES;

   typedef logic [W+2:0] chk_t;
   typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
      logic         p0;
   } res_t;

   logic         clk       = 1'b0;
   logic         rst_n     = 1'b0;
   logic         in_valid  = 1'b0;
   logic         in_ready;
   logic [W-1:0] a         = '0;
   logic [W-1:0] b         = '0;
   logic         cin       = 1'b0;
   logic         sub       = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;
   logic         p0;

   int   n_checks = 0;
   int   n_errors = 0;
   int   n_out    = 0;
   res_t exp_q[$];

   always #5 clk = ~clk;

   skip_adder_pipe #(
      .WIDTH  (W),
      .B      (DEF_B),
      .STAGES (STG)
   ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .p0        (p0)
   );

   task automatic check(input string tag, input chk_t got, input chk_t exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic res_t model(input logic [W-1:0] fa, input logic [W-1:0] fb,
                                  input logic fc, input logic fs);
      logic [W-1:0] ob;
      logic [W:0]   t;
      res_t         r;
      ob     = fs ? ~fb : fb;
      t      = {1'b0, fa} + {1'b0, ob} + {{W{1'b0}}, (fs | fc)};
      r.sum  = t[W-1:0];
      r.cout = t[W];
      r.ovf  = (fa[W-1] == ob[W-1]) && (r.sum[W-1] != fa[W-1]);
      r.p0   = &(fa ^ ob);
      return r;
   endfunction

   function automatic logic [W-1:0] rnd();
      logic [W-1:0] r;
      for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // Accept/deliver decisions are sampled mid-cycle, before the edge that commits them.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
      end else begin
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               check("spurious_out", chk_t'(out_valid), chk_t'(0));
            end else if (out_ready) begin
               check("result", {sum, cout, ovf, p0}, exp_q.pop_front());
               n_out++;
            end else begin
               check("hold", {sum, cout, ovf, p0}, exp_q[0]);
            end
         end
         if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
      end
   end

   task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                       input logic tc, input logic ts);
      int n = 0;
      a        = ta;
      b        = tbv;
      cin      = tc;
      sub      = ts;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check("send_timeout", chk_t'(in_ready), chk_t'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_out(input string tag, output int edges);
      edges = 0;
      while (!out_valid && edges < 40) begin
         @(posedge clk);
         #1;
         edges++;
      end
      check(tag, chk_t'(out_valid), chk_t'(1));
   endtask

   task automatic drain();
      int n = 0;
      out_ready = 1'b1;
      while (exp_q.size() != 0 && n < 300) begin
         @(posedge clk);
         n++;
      end
      #1;
      check("drain", chk_t'(exp_q.size()), chk_t'(0));
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int           edges;
      int           base;
      logic [W-1:0] v;

      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", chk_t'(out_valid), chk_t'(0));
      check("rst_sum", chk_t'(sum), chk_t'(0));
      check("rst_cout", chk_t'(cout), chk_t'(0));
      check("rst_ovf", chk_t'(ovf), chk_t'(0));
      check("rst_p0", chk_t'(p0), chk_t'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("in_ready_after_rst", chk_t'(in_ready), chk_t'(1));

      // All bits propagate: carry-in must skip through every block.
      send('1, '0, 1'b1, 1'b0);
      wait_out("fp_valid", edges);
      check("fp_latency", chk_t'(edges), chk_t'(STG));
      check("fp_sum", chk_t'(sum), chk_t'(0));
      check("fp_cout", chk_t'(cout), chk_t'(1));
      check("fp_p0", chk_t'(p0), chk_t'(1));
      check("fp_ovf", chk_t'(ovf), chk_t'(0));
      repeat (3) @(posedge clk);
      #1;
      check("bubble_valid", chk_t'(out_valid), chk_t'(0));
      check("bubble_sum", chk_t'(sum), chk_t'(0));
      check("bubble_p0", chk_t'(p0), chk_t'(1));

      // 5 - 7 with cin=1, which must be ignored for subtraction.
      send(W'(5), W'(7), 1'b1, 1'b1);
      wait_out("sub_valid", edges);
      v    = '1;
      v[0] = 1'b0;
      check("sub_sum", chk_t'(sum), chk_t'(v));
      check("sub_cout", chk_t'(cout), chk_t'(0));
      check("sub_ovf", chk_t'(ovf), chk_t'(0));
      check("sub_p0", chk_t'(p0), chk_t'(0));
      drain();

      v      = '1;
      v[W-1] = 1'b0;
      send(v, W'(1), 1'b0, 1'b0);
      wait_out("ovf_valid", edges);
      v      = '0;
      v[W-1] = 1'b1;
      check("ovf_sum", chk_t'(sum), chk_t'(v));
      check("ovf_ovf", chk_t'(ovf), chk_t'(1));
      check("ovf_cout", chk_t'(cout), chk_t'(0));
      drain();

      // Backpressure: stall the consumer for three cycles once results start.
      base = n_out;
      fork
         begin
            for (int i = 0; i < 5; i++) send(rnd(), rnd(), 1'($urandom), 1'($urandom));
         end
         begin
            wait_out("bp_start", edges);
            out_ready = 1'b0;
            repeat (3) begin
               @(negedge clk);
               check("bp_in_ready", chk_t'(in_ready), chk_t'(0));
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();
      check("bp_count", chk_t'(n_out - base), chk_t'(5));

      // Reset with three operations in flight and one result waiting.
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) send(rnd(), rnd(), 1'($urandom), 1'($urandom));
      wait_out("rm_setup", edges);
      rst_n = 1'b0;
      #1;
      check("rm_out_valid", chk_t'(out_valid), chk_t'(0));
      check("rm_sum", chk_t'(sum), chk_t'(0));
      @(negedge clk);
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("rm_in_ready", chk_t'(in_ready), chk_t'(1));
      repeat (8) begin
         @(posedge clk);
         #1;
         check("rm_no_stale", chk_t'(out_valid), chk_t'(0));
      end
      base = n_out;
      send(rnd(), rnd(), 1'b1, 1'b0);
      drain();
      check("rm_new_count", chk_t'(n_out - base), chk_t'(1));

      // Random traffic with random consumer stalls.
      base = n_out;
      fork
         begin
            for (int i = 0; i < 30; i++) begin
               repeat ($urandom_range(0, 2)) @(posedge clk);
               #1;
               if (i % 7 == 0) send('1, '0, 1'($urandom), 1'b0);
               else send(rnd(), rnd(), 1'($urandom), 1'($urandom));
            end
         end
         begin
            for (int i = 0; i < 80; i++) begin
               @(posedge clk);
               #1;
               out_ready = 1'($urandom);
            end
            out_ready = 1'b1;
         end
      join
      drain();
      check("rand_count", chk_t'(n_out - base), chk_t'(30));
      check("sb_empty", chk_t'(exp_q.size()), chk_t'(0));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/skip_adder_pipe.md
SKIP_ADDER_PIPE -- requirements
Module: skip_adder_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 128: operand/sum width in bits.
REQ-002 SHALL have parameter B, default 4: carry-skip block width in bits.
REQ-003 SHALL have parameter STAGES, default 4: pipeline segments; each segment is WIDTH/STAGES bits.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port in_valid, input, 1 bit: operands are presented.
REQ-007 SHALL have port in_ready, output, 1 bit: block accepts operands this cycle.
REQ-008 SHALL have ports a and b, input, WIDTH bits each: unsigned or two's-complement operands.
REQ-009 SHALL have port cin, input, 1 bit: carry-in, used for add only.
REQ-010 SHALL have port sub, input, 1 bit: 0 = a+b+cin, 1 = a-b.
REQ-011 SHALL have port out_valid, output, 1 bit: result ports hold a valid result.
REQ-012 SHALL have port out_ready, input, 1 bit: consumer takes the result this cycle.
REQ-013 SHALL have ports sum (WIDTH), cout (1), ovf (1) and p0 (1), all outputs: result, carry-out, signed overflow, and the all-bits-propagate flag.

Function
REQ-014 SHALL accept a transfer on a rising edge where in_valid=1 and in_ready=1; a result is delivered on a rising edge where out_valid=1 and out_ready=1.
REQ-015 SHALL drive advance = !(out_valid && !out_ready); in_ready = advance; all pipeline registers, including valid bits, update only when advance=1.
REQ-016 SHALL compute op_b = sub ? ~b : b and c0 = sub ? 1 : cin; cin SHALL be ignored when sub=1.
REQ-017 SHALL compute segment k (bits k*W/S .. (k+1)*W/S-1) in pipeline stage k+1, using the carry registered from stage k; segment 0 SHALL use c0.
REQ-018 SHALL form each segment from W/(S*B) B-bit ripple blocks; each block SHALL compute its group propagate (AND of a^op_b) and select its carry-out as incoming carry if propagate=1, else ripple carry-out.
REQ-019 SHALL carry the not-yet-summed operand bits, computed sum bits, carry, propagate-AND and the sign bits forward through every stage.
REQ-020 SHALL present the result on the outputs after the STAGES-th advancing edge following the accepting edge (STAGES=1: one edge after capture); throughput SHALL be one result per cycle when out_ready=1.
REQ-021 SHALL set cout = carry out of bit WIDTH-1; for sub, cout=1 means no borrow.
REQ-022 SHALL set ovf = (a[MSB]==op_b[MSB]) && (sum[MSB]!=a[MSB]).
REQ-023 SHALL set p0 = AND over all bits of (a ^ op_b).
REQ-024 SHALL hold sum, cout, ovf, p0 and out_valid stable while out_valid=1 and out_ready=0.
REQ-025 SHALL advance bubbles (valid=0) with the same timing as valid data; result ports SHALL NOT change on an advancing edge when the incoming valid bit is 0.
REQ-026 SHALL deliver results strictly in acceptance order, with no loss and no duplication under any out_ready pattern.
REQ-027 SHALL treat WIDTH % (B*STAGES) != 0 as an elaboration-time error.

Reset
REQ-028 SHALL, while rst_n=0, immediately clear all stage valid bits and out_valid, and drive sum=0, cout=0, ovf=0 and p0=0.
REQ-029 SHALL discard all in-flight operations on a reset assertion; no stale result SHALL appear after rst_n is released.
REQ-030 SHALL drive in_ready=1 in the first cycle after rst_n is released.

Structure
REQ-031 SHALL keep the default WIDTH, B and STAGES values in a shared header included by this block and its bench.
REQ-032 SHALL use one sub-module, skip_block: a B-bit ripple block with group propagate and a 2:1 carry-skip select, instantiated per block through generate.

Verification (WIDTH=128, B=4, STAGES=4)
REQ-033 SHALL check reset: rst_n=0 -> out_valid=0, sum=0, cout=0, ovf=0, p0=0; after release, in_ready=1.
REQ-034 SHALL check full propagate: a=all-ones, b=0, cin=1, sub=0 -> after 4 edges, sum=0, cout=1, p0=1, ovf=0.
REQ-035 SHALL check subtraction: a=5, b=7, sub=1 -> sum=FF..FE, cout=0, ovf=0, p0=0.
REQ-036 SHALL check signed overflow: a=7FF..F, b=1, sub=0, cin=0 -> sum=800..0, ovf=1, cout=0.
REQ-037 SHALL check backpressure: 5 back-to-back ops with out_ready=0 for 3 cycles mid-stream -> in_ready=0 during the stall, outputs held, all 5 results delivered in order.
REQ-038 SHALL check reset mid-operation: rst_n pulsed low with 3 operations in flight -> out_valid=0 at once, and no result appears until new operands are accepted.
